// File: rtl/pll_lock_reset_sequencer_if.sv
// Consumer-side PLL control bundle: lock indication and retry in, resets/status out.
interface pll_lock_reset_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             retry_req;
  logic             pll_rst;
  logic             sys_reset_n;
  logic             pll_fail;
  logic [CNT_W-1:0] lock_loss_count;
  logic [2:0]       state_o;

  modport master (
    input  pll_locked,
    input  retry_req,
    output pll_rst,
    output sys_reset_n,
    output pll_fail,
    output lock_loss_count,
    output state_o
  );

  modport slave (
    output pll_locked,
    output retry_req,
    input  pll_rst,
    input  sys_reset_n,
    input  pll_fail,
    input  lock_loss_count,
    input  state_o
  );
endinterface

// File: rtl/pll_lock_reset_sequencer.sv
// PLL bring-up sequencer on the reference clock: pulses the PLL reset, qualifies lock,
// holds off the system reset, re-sequences on lock loss and gives up after repeated timeouts.
module pll_lock_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 64,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  pll_lock_reset_sequencer_if.master pll_if
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUNNING   = 3'd3,
    ST_FAILED    = 3'd4
  } state_e;

  localparam int RST_W = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
  localparam int TO_W  = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HLD_W = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  // Counters compare against N-1 so each state lasts exactly N cycles.
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic               locked_s;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [STB_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic [HLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [RTY_W-1:0]   retries_q, retries_d;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_reset_n_q, sys_reset_n_d;
  logic               pll_fail_q, pll_fail_d;
  logic               stable_hit_s;
  logic               timeout_hit_s;

  assign locked_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_if.pll_locked};
    end
  end

  // Next-state, per-state counters and registered-output values.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = '0;
    to_cnt_d      = '0;
    stable_cnt_d  = '0;
    hold_cnt_d    = '0;
    retries_d     = retries_q;
    loss_cnt_d    = loss_cnt_q;
    stable_hit_s  = 1'b0;
    timeout_hit_s = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        stable_hit_s  = locked_s && (stable_cnt_q == STB_LAST);
        timeout_hit_s = (to_cnt_q == TO_LAST);
        if (stable_hit_s) begin
          state_d   = ST_HOLD;
          retries_d = '0;
        end else if (timeout_hit_s) begin
          retries_d = retries_q + RTY_W'(1);
          if (retries_q == RTY_LAST) begin
            state_d = ST_FAILED;
          end else begin
            state_d = ST_PLL_RST;
          end
        end else begin
          to_cnt_d     = to_cnt_q + TO_W'(1);
          stable_cnt_d = locked_s ? (stable_cnt_q + STB_W'(1)) : '0;
        end
      end

      ST_HOLD: begin
        // Lock dropping before release is a bring-up restart, not a lock loss.
        if (!locked_s) begin
          state_d = ST_PLL_RST;
        end else if (hold_cnt_q == HLD_LAST) begin
          state_d = ST_RUNNING;
        end else begin
          hold_cnt_d = hold_cnt_q + HLD_W'(1);
        end
      end

      ST_RUNNING: begin
        if (!locked_s) begin
          state_d    = ST_PLL_RST;
          loss_cnt_d = (&loss_cnt_q) ? loss_cnt_q : (loss_cnt_q + CNT_W'(1));
        end else begin
          state_d = ST_RUNNING;
        end
      end

      ST_FAILED: begin
        if (pll_if.retry_req) begin
          state_d   = ST_PLL_RST;
          retries_d = '0;
        end else begin
          state_d = ST_FAILED;
        end
      end

      default: begin
        state_d   = ST_PLL_RST;
        retries_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they switch on the transition edge.
    pll_rst_d     = (state_d == ST_PLL_RST) || (state_d == ST_FAILED);
    sys_reset_n_d = (state_d == ST_RUNNING);
    pll_fail_d    = (state_d == ST_FAILED);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_PLL_RST;
      rst_cnt_q     <= '0;
      to_cnt_q      <= '0;
      stable_cnt_q  <= '0;
      hold_cnt_q    <= '0;
      retries_q     <= '0;
      loss_cnt_q    <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      pll_fail_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      to_cnt_q      <= to_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      retries_q     <= retries_d;
      loss_cnt_q    <= loss_cnt_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      pll_fail_q    <= pll_fail_d;
    end
  end

  assign pll_if.pll_rst         = pll_rst_q;
  assign pll_if.sys_reset_n     = sys_reset_n_q;
  assign pll_if.pll_fail        = pll_fail_q;
  assign pll_if.lock_loss_count = loss_cnt_q;
  assign pll_if.state_o         = state_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed bench for pll_lock_reset_sequencer with short bring-up parameters.
module tb_pll_lock_reset_sequencer;

  localparam int CNT_W = 8;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   exp_loss;

  pll_lock_reset_sequencer_if #(.CNT_W(CNT_W)) pif ();

  pll_lock_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (5),
    .MAX_RETRIES   (3),
    .CNT_W         (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pll_if  (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic prst,
                         input logic srn, input logic fail, input logic [CNT_W-1:0] loss);
    chk({tag, ".state"}, {29'd0, pif.state_o}, {29'd0, st});
    chk({tag, ".pll_rst"}, {31'd0, pif.pll_rst}, {31'd0, prst});
    chk({tag, ".sys_reset_n"}, {31'd0, pif.sys_reset_n}, {31'd0, srn});
    chk({tag, ".pll_fail"}, {31'd0, pif.pll_fail}, {31'd0, fail});
    chk({tag, ".loss"}, {24'd0, pif.lock_loss_count}, {24'd0, loss});
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b1;
    pif.pll_locked = 1'b1;
    pif.retry_req  = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    reset_n = 1'b1;

    // Clean bring-up: edge numbers count from reset release.
    step(3);  chk_all("e3_pll_rst", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    step(1);  chk_all("e4_wait", 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(7);  chk_all("e11_wait", 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1);  chk_all("e12_hold", 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4);  chk_all("e16_hold", 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1);  chk_all("e17_run", 3'd3, 1'b0, 1'b1, 1'b0, 8'd0);

    // One-cycle lock drop while running.
    pif.pll_locked = 1'b0;
    step(1);  chk_all("e18_run", 3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
    pif.pll_locked = 1'b1;
    step(1);  chk_all("e19_run", 3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1);  chk_all("e20_loss", 3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
    step(3);  chk_all("e23_pll_rst", 3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
    step(1);  chk_all("e24_wait", 3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
    step(12); chk_all("e36_hold", 3'd2, 1'b0, 1'b0, 1'b0, 8'd1);
    step(1);  chk_all("e37_run", 3'd3, 1'b0, 1'b1, 1'b0, 8'd1);

    // Lock lost for good: one lock loss, then three timeouts into FAILED.
    pif.pll_locked = 1'b0;
    step(3);  chk_all("e40_loss", 3'd0, 1'b1, 1'b0, 1'b0, 8'd2);
    step(4);  chk_all("e44_wait1", 3'd1, 1'b0, 1'b0, 1'b0, 8'd2);
    step(99); chk_all("e143_wait1", 3'd1, 1'b0, 1'b0, 1'b0, 8'd2);
    step(1);  chk_all("e144_to1", 3'd0, 1'b1, 1'b0, 1'b0, 8'd2);
    step(4);  chk_all("e148_wait2", 3'd1, 1'b0, 1'b0, 1'b0, 8'd2);
    step(100); chk_all("e248_to2", 3'd0, 1'b1, 1'b0, 1'b0, 8'd2);
    step(4);  chk_all("e252_wait3", 3'd1, 1'b0, 1'b0, 1'b0, 8'd2);
    step(99); chk_all("e351_wait3", 3'd1, 1'b0, 1'b0, 1'b0, 8'd2);
    step(1);  chk_all("e352_failed", 3'd4, 1'b1, 1'b0, 1'b1, 8'd2);
    step(10); chk_all("e362_failed", 3'd4, 1'b1, 1'b0, 1'b1, 8'd2);
    pif.retry_req = 1'b1;
    step(1);  chk_all("e363_retry", 3'd0, 1'b1, 1'b0, 1'b0, 8'd2);
    pif.retry_req = 1'b0;

    // Lock chattering 3 high / 3 low never qualifies; three timeouts again.
    for (int i = 0; i < 312; i++) begin
      pif.pll_locked = ((i / 3) % 2) == 0;
      step(1);
      if (i == 103) chk_all("toggle_to1", 3'd0, 1'b1, 1'b0, 1'b0, 8'd2);
      if (i == 107) chk_all("toggle_wait2", 3'd1, 1'b0, 1'b0, 1'b0, 8'd2);
    end
    chk_all("toggle_failed", 3'd4, 1'b1, 1'b0, 1'b1, 8'd2);
    pif.pll_locked = 1'b1;
    pif.retry_req  = 1'b1;
    step(1);  chk_all("e676_retry", 3'd0, 1'b1, 1'b0, 1'b0, 8'd2);
    pif.retry_req = 1'b0;
    step(4);  chk_all("e680_wait", 3'd1, 1'b0, 1'b0, 1'b0, 8'd2);
    step(8);  chk_all("e688_hold", 3'd2, 1'b0, 1'b0, 1'b0, 8'd2);

    // Lock drop during HOLD restarts without counting a loss.
    pif.pll_locked = 1'b0;
    step(1);  chk_all("e689_hold", 3'd2, 1'b0, 1'b0, 1'b0, 8'd2);
    pif.pll_locked = 1'b1;
    step(1);  chk_all("e690_hold", 3'd2, 1'b0, 1'b0, 1'b0, 8'd2);
    step(1);  chk_all("e691_restart", 3'd0, 1'b1, 1'b0, 1'b0, 8'd2);
    step(17); chk_all("e708_run", 3'd3, 1'b0, 1'b1, 1'b0, 8'd2);

    // 300 further lock losses; the count saturates at all-ones.
    exp_loss = 2;
    for (int k = 0; k < 300; k++) begin
      pif.pll_locked = 1'b0;
      step(1);
      pif.pll_locked = 1'b1;
      step(2);
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      chk("sat_loss", {24'd0, pif.lock_loss_count}, exp_loss);
      step(17);
    end
    chk_all("sat_run", 3'd3, 1'b0, 1'b1, 1'b0, 8'd255);

    // Asynchronous reset in the middle of WAIT_LOCK.
    pif.pll_locked = 1'b0;
    step(1);
    pif.pll_locked = 1'b1;
    step(2);
    step(6);  chk_all("mid_wait", 3'd1, 1'b0, 1'b0, 1'b0, 8'd255);
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    reset_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
